// File: rtl/definitions.sv
// definitions: shared XM stage types, state encoding and counter width
package definitions;
    localparam int STALL_CNT_W = 16;
    localparam int XM_DATA_W = 32;
    localparam int XM_ADDR_W = 5;
    localparam int XM_CTRL_W = 8;
    typedef enum logic [1:0] {EMPTY, FULL, FULL_SKID} XmStageState;
    typedef struct packed {
        logic [XM_CTRL_W-1:0] ctrl;
        logic [XM_ADDR_W-1:0] dst;
        logic [XM_DATA_W-1:0] addr;
        logic [XM_DATA_W-1:0] val;
    } XmEntry;
endpackage

// File: rtl/xm_stage_buf_skid.sv
// xm_skid_slot: one-entry holding register with load/unload strobes and clear
module xm_skid_slot
    import definitions::*;
#(
    parameter type entry_t = XmEntry
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   load,
    input  logic   unload,
    input  entry_t d,
    output logic   valid,
    output entry_t q
);
    logic   valid_q, valid_d;
    entry_t q_q, q_d;
    // clear beats load, load beats unload; data only changes on load
    always_comb begin
        valid_d = clr ? 1'b0 : load ? 1'b1 : unload ? 1'b0 : valid_q;
        q_d     = (load && !clr) ? d : q_q;
    end
    // slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            q_q     <= '0;
        end else begin
            valid_q <= valid_d;
            q_q     <= q_d;
        end
    end
    assign valid = valid_q;
    assign q     = q_q;
endmodule

// File: rtl/xm_stage_buf.sv
// xm_stage_buf: execute->memory stage register with handshake, flush, store-data forwarding and stall counter; optional skid slot via XM_STAGE_SKID_EN
module xm_stage_buf
    import definitions::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 8,
    parameter int NFWD   = 2,
    localparam int SEL_W = $clog2(NFWD + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [CTRL_W-1:0]      x_ctrl,
    input  logic [ADDR_W-1:0]      x_dst,
    input  logic [DATA_W-1:0]      x_alu,
    input  logic [DATA_W-1:0]      x_rt,
    input  logic [SEL_W-1:0]       fwd_sel,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CTRL_W-1:0]      m_ctrl,
    output logic [ADDR_W-1:0]      m_dst,
    output logic [DATA_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_val,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] val;
    } entry_t;

    XmStageState            state_q, state_d;
    entry_t                 entry_q, entry_d, in_e;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   fire_in, fire_out;

    // store data is resolved here so the captured value no longer tracks the sources
    always_comb begin
        in_e = '{ctrl: x_ctrl, dst: x_dst, addr: x_alu, val: x_rt};
        for (int i = 0; i < NFWD; i++)
            if (fwd_sel == SEL_W'(i + 1)) in_e.val = fwd_data[i*DATA_W +: DATA_W];
    end

    assign m_valid  = state_q != EMPTY;
    assign fire_in  = x_valid && x_ready && !flush;
    assign fire_out = m_valid && m_ready;

`ifdef XM_STAGE_SKID_EN
    logic   skid_valid, skid_load, skid_unload;
    entry_t skid_q;

    // ready comes only from registered skid occupancy, never from m_ready
    assign x_ready = !rst && !skid_valid;

    xm_skid_slot #(.entry_t(entry_t)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .load   (skid_load),
        .unload (skid_unload),
        .d      (in_e),
        .valid  (skid_valid),
        .q      (skid_q)
    );

    // flush wins; a stalled capture parks in the skid slot, which drains first
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else if (state_q == FULL_SKID) begin
            if (fire_out) begin
                state_d     = FULL;
                entry_d     = skid_q;
                skid_unload = 1'b1;
            end
        end else if (fire_in && state_q == FULL && !m_ready) begin
            state_d   = FULL_SKID;
            skid_load = 1'b1;
        end else if (fire_in) begin
            state_d = FULL;
            entry_d = in_e;
        end else if (fire_out) begin
            state_d = EMPTY;
        end
    end
`else
    assign x_ready = !rst && (!m_valid || m_ready);

    // flush wins; capture fills or replaces, a lone consume empties
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (fire_in) begin
            state_d = FULL;
            entry_d = in_e;
        end else if (fire_out) begin
            state_d = EMPTY;
        end
    end
`endif

    // stalled cycles saturate; flush does not clear the count
    always_comb stall_d = (m_valid && !m_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;

    // stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            entry_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            stall_q <= stall_d;
        end
    end

    assign m_ctrl    = m_valid ? entry_q.ctrl : '0;
    assign m_dst     = m_valid ? entry_q.dst : '0;
    assign m_addr    = entry_q.addr;
    assign m_val     = entry_q.val;
    assign stall_cnt = stall_q;
endmodule

// File: doc/xm_stage_buf.md
# xm_stage_buf

Parametrised execute→memory pipeline stage register with a valid/ready handshake, synchronous flush, N-way store-data forwarding resolved at capture, and a saturating stall counter. It sits between the execute stage and the memory stage. It generalises the fixed single-forward XM register so that memory-stage back-pressure (multi-cycle data memory) is absorbed without losing instructions. An optional one-entry skid slot registers the upstream ready.

## Interface
Parameters:
- `DATA_W`, 32, width of ALU result and store data
- `ADDR_W`, 5, destination register address width
- `CTRL_W`, 8, packed XM control word width (memory and writeback controls)
- `NFWD`, 2, number of store-data forwarding sources (≥1)
- `SEL_W`, `$clog2(NFWD+1)`, forwarding select width (derived, not overridden)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `x_valid` in 1: execute stage presents an instruction
- `x_ready` out 1: stage accepts this cycle
- `x_ctrl` in CTRL_W: control word
- `x_dst` in ADDR_W: destination register
- `x_alu` in DATA_W: ALU result, used as memory address
- `x_rt` in DATA_W: unforwarded store data
- `fwd_sel` in SEL_W: 0 selects `x_rt`; k in 1..NFWD selects source k-1
- `fwd_data` in NFWD*DATA_W: forwarding sources, source i at bits [i*DATA_W +: DATA_W]
- `flush` in 1: kill all held and incoming entries
- `m_valid` out 1: output entry valid
- `m_ready` in 1: memory stage consumes
- `m_ctrl` out CTRL_W, `m_dst` out ADDR_W, `m_addr` out DATA_W, `m_val` out DATA_W: held entry
- `stall_cnt` out 16: cycles with `m_valid & !m_ready`, saturating

## Operation
- Capture (fire_in) = `x_valid & x_ready & !flush`. Output (fire_out) = `m_valid & m_ready`.
- Store data is muxed at capture. If `fwd_sel` > NFWD, `x_rt` is used. The selected value is stored, so a later change in the forwarding sources does not affect the entry.
- Bubble rule: whenever `m_valid`=0, `m_ctrl` and `m_dst` are 0. `m_addr` and `m_val` are don't-care but hold their last value.
- Without skid, the states are EMPTY and FULL:
  - `x_ready = !rst & (!m_valid | m_ready)`.
  - EMPTY→FULL on fire_in.
  - FULL→FULL on fire_in & fire_out (replace).
  - FULL→EMPTY on fire_out & !fire_in.
- `flush` has priority over everything. Next state is EMPTY, the skid slot is invalidated, and the incoming instruction is dropped.
- `stall_cnt` increments when `m_valid & !m_ready` and saturates at 16'hFFFF. Only `rst` clears it; `flush` does not.
- Reset values: `m_valid`=0, `m_ctrl`=0, `m_dst`=0, `m_addr`=0, `m_val`=0, `stall_cnt`=0, state EMPTY, skid empty. `x_ready`=0 while `rst` is high.

## Timing
- Latency: one cycle from fire_in to the entry appearing on the `m_*` outputs.
- Throughput: one instruction per cycle with `m_ready` held high.
- Without skid, `x_ready` depends combinationally on `m_ready`.
- Simultaneous fire_in and fire_out in FULL replaces the entry with no bubble.
- `rst` asserted mid-stall clears all state immediately; the held entry is lost.
- Reset deassertion is synchronised externally; the first capture is possible on the first edge after deassertion.

## Configuration
- `XM_STAGE_SKID_EN` defined: adds a one-entry skid slot and state FULL_SKID.
  - `x_ready` becomes a register: `!skid_valid`, reset to 1 after `rst` releases. There is no combinational path from `m_ready`.
  - fire_in while FULL & !m_ready moves to FULL_SKID.
  - In FULL_SKID, on fire_out the skid entry moves to the output in the same edge → FULL, and `x_ready` rises next cycle.
  - Order is strictly preserved.
- Not defined: two-state behaviour as described in Operation. No skid storage is inferred.

## Structure
- Shared package `definitions`:
  - `XmStageState` enum {EMPTY, FULL, FULL_SKID}
  - packed struct `XmEntry` {ctrl, dst, addr, val}
  - constant `STALL_CNT_W`=16
- Optional sub-module `xm_skid_slot`: one `XmEntry` register plus a valid bit, with load and unload strobes. It is instantiated only under `XM_STAGE_SKID_EN`.

## Test plan
- Reset, then `x_valid`=1, `x_dst`=5'd7, `x_alu`=32'h100, `fwd_sel`=0, `x_rt`=32'hAA, `m_ready`=1 → next cycle `m_valid`=1, `m_dst`=7, `m_addr`=32'h100, `m_val`=32'hAA.
- `fwd_sel`=2 with `fwd_data[1]`=32'hDEAD, then change `fwd_data[1]` to 0 while stalled → `m_val` stays 32'hDEAD. `fwd_sel`=3 (out of range, NFWD=2) → `m_val`=`x_rt`.
- Hold `m_ready`=0 for 5 cycles with an entry held → `stall_cnt`=5. Force 70000 stall cycles → `stall_cnt`=16'hFFFF.
- With `XM_STAGE_SKID_EN`: stream A,B,C with `m_ready`=0 → A held, B in skid, `x_ready`=0, C not accepted. Raise `m_ready` → outputs A,B,C in order, no loss or duplication.
- `flush` in the same cycle as `x_valid`, with an entry held (and skid full in skid mode) → next cycle `m_valid`=0, `m_ctrl`=0, `m_dst`=0, and the incoming entry never appears.
- Assert `rst` mid-stream between edges → all outputs zero immediately, before the next clock edge.
